// File: rtl/uart_tx_param_if.sv
// Host-side bundle for the parameterised UART transmitter: character push
// strobe/data, per-frame line configuration, and transmitter status.
interface uart_tx_param_if #(
  parameter int DATA_W     = 8,
  parameter int K_W        = 20,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic              Load;
  logic [DATA_W-1:0] out_port;
  logic              eight;
  logic              pen;
  logic              ohel;
  logic              two_stop;
  logic [K_W-1:0]    k;
  logic              txrdy;
  logic              transfer;
  logic              tx_busy;
  logic [CW-1:0]     fifo_count;
  logic              overflow;

  // Host side: pushes characters and sets line format, observes status.
  modport master (
    output Load, out_port, eight, pen, ohel, two_stop, k,
    input  txrdy, transfer, tx_busy, fifo_count, overflow
  );

  // Transmitter side.
  modport slave (
    input  Load, out_port, eight, pen, ohel, two_stop, k,
    output txrdy, transfer, tx_busy, fifo_count, overflow
  );
endinterface

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a small transmit FIFO.
// Line format (data width, parity, stop bits, baud divisor) is captured when
// a character leaves the FIFO, so host changes only affect later frames.
// The serial output is registered one clock behind the state register, so a
// Load into an empty idle transmitter drops the line two edges later.
module uart_tx_param #(
  parameter int DATA_W     = 8,
  parameter int K_W        = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_param_if.slave    bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0]    LAST_FULL  = 4'(DATA_W - 1);
  localparam logic [3:0]    LAST_SHORT = 4'(DATA_W - 2);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Parity bit that makes the total number of ones odd (odd=1) or even (odd=0).
  function automatic logic parity_of(input logic [DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // FIFO storage
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              overflow_r;

  // Frame engine
  state_t            state;
  logic [K_W-1:0]    cnt;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic              lat_eight;
  logic              lat_pen;
  logic              lat_two_stop;
  logic [K_W-1:0]    lat_k;
  logic              transfer_r;

  logic              full;
  logic              push;
  logic              pop;
  logic              bit_done;
  logic              frame_end;
  logic [3:0]        last_idx;
  logic [DATA_W-1:0] head_masked;

  assign full      = (count == FULL_COUNT);
  assign push      = bus.Load & ~full;
  assign bit_done  = (cnt == {K_W{1'b0}});
  assign frame_end = (state == STOP) & bit_done & (~lat_two_stop | (bit_cnt == 4'd1));
  assign pop       = (count != {CW{1'b0}}) & ((state == IDLE) | frame_end);
  assign last_idx  = lat_eight ? LAST_FULL : LAST_SHORT;

  // Head character with the unused MSB cleared for short characters.
  always_comb begin
    head_masked = mem[rd_ptr];
    if (bus.eight) begin
      head_masked[DATA_W-1] = mem[rd_ptr][DATA_W-1];
    end else begin
      head_masked[DATA_W-1] = 1'b0;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= {DATA_W{1'b0}};
      end
      wr_ptr     <= {AW{1'b0}};
      rd_ptr     <= {AW{1'b0}};
      count      <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.out_port;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bus.Load && full) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Frame state machine: bit timing, shifting and registered serial output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= {K_W{1'b0}};
      bit_cnt      <= 4'd0;
      shreg        <= {DATA_W{1'b0}};
      par_bit      <= 1'b0;
      lat_eight    <= 1'b0;
      lat_pen      <= 1'b0;
      lat_two_stop <= 1'b0;
      lat_k        <= {K_W{1'b0}};
      transfer_r   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          transfer_r <= 1'b1;
        end
        START: begin
          transfer_r <= 1'b0;
          if (bit_done) begin
            state   <= DATA;
            cnt     <= lat_k;
            bit_cnt <= 4'd0;
          end else begin
            cnt <= cnt - K_W'(1);
          end
        end
        DATA: begin
          transfer_r <= shreg[0];
          if (bit_done) begin
            shreg <= shreg >> 1;
            cnt   <= lat_k;
            if (bit_cnt == last_idx) begin
              state   <= lat_pen ? PARITY : STOP;
              bit_cnt <= 4'd0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            cnt <= cnt - K_W'(1);
          end
        end
        PARITY: begin
          transfer_r <= par_bit;
          if (bit_done) begin
            state   <= STOP;
            cnt     <= lat_k;
            bit_cnt <= 4'd0;
          end else begin
            cnt <= cnt - K_W'(1);
          end
        end
        STOP: begin
          transfer_r <= 1'b1;
          if (frame_end) begin
            state <= IDLE;
          end else if (bit_done) begin
            cnt     <= lat_k;
            bit_cnt <= 4'd1;
          end else begin
            cnt <= cnt - K_W'(1);
          end
        end
        default: begin
          state      <= IDLE;
          transfer_r <= 1'b1;
        end
      endcase
      // Starting a frame (from idle or straight out of the last stop bit)
      // overrides whatever the state branch chose.
      if (pop) begin
        state        <= START;
        shreg        <= head_masked;
        par_bit      <= parity_of(head_masked, bus.ohel);
        lat_eight    <= bus.eight;
        lat_pen      <= bus.pen;
        lat_two_stop <= bus.two_stop;
        lat_k        <= bus.k;
        cnt          <= bus.k;
        bit_cnt      <= 4'd0;
      end
    end
  end

  assign bus.txrdy      = ~full;
  assign bus.transfer   = transfer_r;
  assign bus.tx_busy    = (state != IDLE) | (count != {CW{1'b0}});
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: reset state, frame formats, config
// latching, FIFO fill/overflow with back-to-back frames, mid-frame reset.
module tb_uart_tx_param;
  localparam int DATA_W     = 8;
  localparam int K_W        = 20;
  localparam int FIFO_DEPTH = 4;
  localparam int MAXC       = 256;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  uart_tx_param_if #(.DATA_W(DATA_W), .K_W(K_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  uart_tx_param #(.DATA_W(DATA_W), .K_W(K_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] load_data [0:7];
  logic       exp_q [$];
  logic       cap_line [0:MAXC-1];
  logic       cap_busy [0:MAXC-1];
  logic       cap_rdy  [0:MAXC-1];
  logic       cap_ovf  [0:MAXC-1];
  logic [2:0] cap_cnt  [0:MAXC-1];

  // Append a frame written in transmission order (pat[nbits-1] goes first).
  task automatic add_frame(input logic [15:0] pat, input int nbits, input int kk);
    for (int i = nbits - 1; i >= 0; i--) begin
      for (int c = 0; c <= kk; c++) exp_q.push_back(pat[i]);
    end
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
  endtask

  // Sample outputs each falling edge, then drive Load for the first nloads cycles.
  task automatic capture(input int nloads, input int ncycles, input bit perturb);
    for (int n = 0; n < ncycles; n++) begin
      @(negedge clk);
      cap_line[n] = bus.transfer;
      cap_busy[n] = bus.tx_busy;
      cap_rdy[n]  = bus.txrdy;
      cap_ovf[n]  = bus.overflow;
      cap_cnt[n]  = bus.fifo_count;
      if (n < nloads) begin
        bus.Load     = 1'b1;
        bus.out_port = load_data[n];
      end else begin
        bus.Load     = 1'b0;
      end
      if (perturb && n == 4) begin
        bus.k = 20'd2; bus.pen = 1'b0; bus.ohel = ~bus.ohel;
        bus.eight = 1'b0; bus.two_stop = 1'b1;
      end
    end
  endtask

  task automatic set_cfg(input logic e, input logic p, input logic o,
                         input logic ts, input logic [K_W-1:0] kk);
    @(negedge clk);
    bus.eight = e; bus.pen = p; bus.ohel = o; bus.two_stop = ts; bus.k = kk;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.Load = 1'b0; bus.out_port = 8'h00;
    bus.eight = 1'b1; bus.pen = 1'b0; bus.ohel = 1'b0; bus.two_stop = 1'b0; bus.k = 20'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.transfer, bus.txrdy, bus.tx_busy, bus.overflow, bus.fifo_count} !== 7'b1100_000) begin
      errors++;
      $display("FAIL reset_state: got line=%b rdy=%b busy=%b ovf=%b cnt=%0d expected 1 1 0 0 0",
               bus.transfer, bus.txrdy, bus.tx_busy, bus.overflow, bus.fifo_count);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.transfer !== 1'b1 || bus.tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got line=%b busy=%b expected 1 0", bus.transfer, bus.tx_busy);
    end
  endtask

  // One character, whole-waveform check against a hand-written bit pattern.
  task automatic test_single_frame(input string name, input logic [7:0] d,
                                   input logic e, input logic p, input logic o,
                                   input logic ts, input int kk,
                                   input logic [15:0] pat, input int nbits,
                                   input bit perturb);
    int last;
    set_cfg(e, p, o, ts, K_W'(kk));
    load_data[0] = d;
    exp_q.delete();
    add_idle(3);
    add_frame(pat, nbits, kk);
    add_idle(4);
    capture(1, exp_q.size(), perturb);
    for (int n = 0; n < exp_q.size(); n++) begin
      checks++;
      if (cap_line[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL %s line cycle %0d: got %b expected %b", name, n, cap_line[n], exp_q[n]);
      end
    end
    last = exp_q.size() - 1;
    checks++;
    if (cap_busy[3] !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_mid: got %b expected 1", name, cap_busy[3]);
    end
    checks++;
    if (cap_busy[last] !== 1'b0 || cap_cnt[last] !== 3'd0) begin
      errors++;
      $display("FAIL %s idle_after: got busy=%b cnt=%0d expected 0 0", name, cap_busy[last], cap_cnt[last]);
    end
  endtask

  task automatic test_back_to_back();
    int last;
    set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 20'd1);
    load_data[0] = 8'h01; load_data[1] = 8'h02; load_data[2] = 8'h03;
    load_data[3] = 8'h04; load_data[4] = 8'h05; load_data[5] = 8'h06;
    exp_q.delete();
    add_idle(3);
    add_frame(16'b0100000001, 10, 1);
    add_frame(16'b0010000001, 10, 1);
    add_frame(16'b0110000001, 10, 1);
    add_frame(16'b0001000001, 10, 1);
    add_frame(16'b0101000001, 10, 1);
    add_idle(4);
    capture(6, exp_q.size(), 1'b0);
    for (int n = 0; n < exp_q.size(); n++) begin
      checks++;
      if (cap_line[n] !== exp_q[n]) begin
        errors++;
        $display("FAIL b2b line cycle %0d: got %b expected %b", n, cap_line[n], exp_q[n]);
      end
    end
    checks++;
    if (cap_cnt[5] !== 3'd4 || cap_rdy[5] !== 1'b0) begin
      errors++;
      $display("FAIL b2b full: got cnt=%0d rdy=%b expected 4 0", cap_cnt[5], cap_rdy[5]);
    end
    checks++;
    if (cap_ovf[5] !== 1'b0) begin
      errors++;
      $display("FAIL b2b ovf_before_drop: got %b expected 0", cap_ovf[5]);
    end
    checks++;
    if (cap_ovf[6] !== 1'b1 || cap_cnt[6] !== 3'd4) begin
      errors++;
      $display("FAIL b2b drop: got ovf=%b cnt=%0d expected 1 4", cap_ovf[6], cap_cnt[6]);
    end
    last = exp_q.size() - 1;
    checks++;
    if (cap_busy[last] !== 1'b0 || cap_cnt[last] !== 3'd0 || cap_rdy[last] !== 1'b1) begin
      errors++;
      $display("FAIL b2b drained: got busy=%b cnt=%0d rdy=%b expected 0 0 1",
               cap_busy[last], cap_cnt[last], cap_rdy[last]);
    end
    checks++;
    if (cap_ovf[last] !== 1'b1) begin
      errors++;
      $display("FAIL b2b ovf_sticky: got %b expected 1", cap_ovf[last]);
    end
  endtask

  task automatic test_reset_mid_frame();
    set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 20'd3);
    load_data[0] = 8'h00; load_data[1] = 8'h00; load_data[2] = 8'h00;
    capture(3, 9, 1'b0);
    checks++;
    if (cap_line[8] !== 1'b0 || cap_cnt[8] !== 3'd2 || cap_busy[8] !== 1'b1) begin
      errors++;
      $display("FAIL midrst pre: got line=%b cnt=%0d busy=%b expected 0 2 1",
               cap_line[8], cap_cnt[8], cap_busy[8]);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.transfer, bus.txrdy, bus.tx_busy, bus.overflow, bus.fifo_count} !== 7'b1100_000) begin
      errors++;
      $display("FAIL midrst immediate: got line=%b rdy=%b busy=%b ovf=%b cnt=%0d expected 1 1 0 0 0",
               bus.transfer, bus.txrdy, bus.tx_busy, bus.overflow, bus.fifo_count);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      checks++;
      if (bus.transfer !== 1'b1 || bus.tx_busy !== 1'b0 || bus.fifo_count !== 3'd0) begin
        errors++;
        $display("FAIL midrst after cycle %0d: got line=%b busy=%b cnt=%0d expected 1 0 0",
                 n, bus.transfer, bus.tx_busy, bus.fifo_count);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_frame("odd_parity",  8'hB9, 1'b1, 1'b1, 1'b1, 1'b0, 9, 16'b01001110101, 11, 1'b0);
    test_single_frame("even_parity", 8'hB9, 1'b1, 1'b1, 1'b0, 1'b0, 9, 16'b01001110111, 11, 1'b0);
    test_single_frame("seven_bit",   8'h41, 1'b0, 1'b0, 1'b0, 1'b1, 3, 16'b0100000111, 10, 1'b0);
    test_single_frame("k_zero",      8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 0, 16'b001011010011, 12, 1'b0);
    test_single_frame("cfg_latch",   8'hB9, 1'b1, 1'b1, 1'b1, 1'b0, 9, 16'b01001110101, 11, 1'b1);
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DATA_W, default 8: maximum character width in bits, legal range 6..9.
REQ-002 Parameter K_W, default 20: width of baud divisor input k.
REQ-003 Parameter FIFO_DEPTH, default 4: transmit FIFO entries, power of two, 2..64.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 Load  in  1  write strobe; one character pushed per cycle high.
REQ-007 out_port  in  DATA_W  character to push.
REQ-008 eight  in  1  1: DATA_W data bits; 0: DATA_W-1 data bits, out_port MSB ignored.
REQ-009 pen  in  1  parity enable.
REQ-010 ohel  in  1  parity sense; 1 odd, 0 even.
REQ-011 two_stop  in  1  1: two stop bits; 0: one.
REQ-012 k  in  K_W  baud divisor; bit time = k+1 clocks.
REQ-013 txrdy  out  1  FIFO not full.
REQ-014 transfer  out  1  serial line, idle high.
REQ-015 tx_busy  out  1  frame in progress or FIFO non-empty.
REQ-016 fifo_count  out  clog2(FIFO_DEPTH)+1  entries held.
REQ-017 overflow  out  1  sticky flag, Load dropped while full.

Function
REQ-018 Load high with txrdy high shall write out_port into FIFO tail; Load with txrdy low shall be dropped and set overflow.
REQ-019 txrdy shall be combinational !(fifo_count==FIFO_DEPTH); a same-cycle pop shall not make a Load at full acceptable.
REQ-020 States IDLE, START, DATA, PARITY, STOP; transfer registered, driven 1 in IDLE and STOP, 0 in START.
REQ-021 IDLE with FIFO non-empty: pop head into shift register, latch eight, pen, ohel, two_stop, k, go START; mid-frame changes to these inputs shall not affect the current frame.
REQ-022 Load into empty FIFO while IDLE: transfer shall fall at the second rising edge after the Load edge.
REQ-023 Each bit shall hold exactly k+1 clocks via a K_W-bit down-counter reloaded per bit; k=0 gives 1-clock bits.
REQ-024 DATA sends LSB first, DATA_W or DATA_W-1 bits per latched eight.
REQ-025 PARITY entered only if pen; bit = XOR of sent data bits, inverted when ohel=1, so total ones incl. parity is odd (ohel=1) or even (ohel=0).
REQ-026 STOP lasts 1 or 2 bit times per latched two_stop.
REQ-027 End of STOP with FIFO non-empty: next START begins the following clock with no idle bit; else IDLE.
REQ-028 Push and pop in the same cycle shall leave fifo_count unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-029 tx_busy = (state!=IDLE) | (fifo_count!=0).

Reset
REQ-030 reset high shall immediately force: state IDLE, transfer=1, FIFO empty, fifo_count=0, txrdy=1, tx_busy=0, overflow=0, counters 0.
REQ-031 Reset mid-frame shall abort the frame with transfer high on assertion; no partial frame resumes after release.
REQ-032 overflow shall clear only on reset.

Verification
REQ-033 k=9, eight=1, pen=1, ohel=1, two_stop=0, single Load 0xB9 -> transfer 0,1,0,0,1,1,1,0,1,0,1, each 10 clocks, 110 clocks total, then idle high, tx_busy low.
REQ-034 Same with ohel=0 -> parity bit 1, frame otherwise identical.
REQ-035 k=3, eight=0, pen=0, two_stop=1, Load 0x41 -> 0,1,0,0,0,0,0,1,1,1, each 4 clocks, 40 clocks.
REQ-036 FIFO_DEPTH=4, six consecutive Load pulses while idle -> first popped, next four fill FIFO (fifo_count=4, txrdy=0), sixth dropped, overflow=1; five frames sent back-to-back without idle gap.
REQ-037 reset asserted mid-DATA with 2 queued -> transfer=1, fifo_count=0 same cycle; no further frames after release.
REQ-038 k=0 single Load -> every bit exactly 1 clock; frame length matches configured bit count.
